// File: rtl/picosoc_bus_xbar.sv
// Native-bus address decoder and response mux between the picorv32 mem_* port and N slaves.
// Base/mask region table, per-transaction timeout, error response and sticky error status.
//
// state  | meaning
// IDLE   | waiting for mem_valid; decode and latch slave select
// ACTIVE | s_valid to the selected slave; wait for s_ready or timeout
// RESP   | registered read data returned (REG_RESPONSE=1 only)
// ERR    | error response with ERR_DATA (unmapped or timed out)
module picosoc_bus_xbar #(
  parameter int                       NUM_SLAVES     = 4,
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE     = {NUM_SLAVES{32'h0}},
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_MASK     = {NUM_SLAVES{32'hFFFF_FFFF}},
  parameter int                       TIMEOUT_CYCLES = 255,
  parameter bit                       REG_RESPONSE   = 1'b0,
  parameter logic [31:0]              ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mem_valid,
  input  logic                       mem_instr,
  output logic                       mem_ready,
  input  logic [31:0]                mem_addr,
  input  logic [31:0]                mem_wdata,
  input  logic [3:0]                 mem_wstrb,
  output logic [31:0]                mem_rdata,
  output logic [NUM_SLAVES-1:0]      s_valid,
  input  logic [NUM_SLAVES-1:0]      s_ready,
  output logic [31:0]                s_addr,
  output logic [31:0]                s_wdata,
  output logic [3:0]                 s_wstrb,
  output logic                       s_instr,
  input  logic [32*NUM_SLAVES-1:0]   s_rdata,
  output logic                       err_flag,
  output logic [31:0]                err_addr,
  output logic [7:0]                 err_count,
  input  logic                       err_clr
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP, ERR} state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] sel, hit_idx;
  logic             hit;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      rdata_q;
  logic [31:0]      s_rdata_arr [NUM_SLAVES];
  logic             sel_ready, timeout, err_event;

  assign s_addr  = mem_addr;
  assign s_wdata = mem_wdata;
  assign s_wstrb = mem_wstrb;
  assign s_instr = mem_instr;

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_rdata
    assign s_rdata_arr[g] = s_rdata[32*g +: 32];
  end

  // Walk from the top index down so the lowest matching index is the last written.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((mem_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  assign sel_ready = s_ready[sel];
  assign timeout   = TO_EN && (cnt == TO_LAST);
  assign err_event = ((state == IDLE) && mem_valid && !hit) ||
                     ((state == ACTIVE) && mem_valid && !sel_ready && timeout);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (mem_valid) state_nxt = hit ? ACTIVE : ERR;
      ACTIVE: begin
        if (!mem_valid)     state_nxt = IDLE;
        else if (sel_ready) state_nxt = REG_RESPONSE ? RESP : IDLE;
        else if (timeout)   state_nxt = ERR;
      end
      RESP:   state_nxt = IDLE;
      ERR:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_valid   = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    case (state)
      ACTIVE: begin
        s_valid[sel] = 1'b1;
        if (!REG_RESPONSE) begin
          mem_rdata = s_rdata_arr[sel];
          mem_ready = mem_valid && sel_ready;
        end
      end
      RESP: begin
        mem_ready = 1'b1;
        mem_rdata = rdata_q;
      end
      ERR: begin
        mem_ready = 1'b1;
        mem_rdata = ERR_DATA;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel       <= '0;
      cnt       <= '0;
      rdata_q   <= '0;
      err_flag  <= 1'b0;
      err_addr  <= '0;
      err_count <= '0;
    end else begin
      if (state == IDLE) begin
        cnt <= '0;
        if (mem_valid) sel <= hit_idx;
      end else if (state == ACTIVE) begin
        cnt <= cnt + 1'b1;
      end

      if ((state == ACTIVE) && sel_ready) rdata_q <= s_rdata_arr[sel];

      // A new error in the same cycle as err_clr takes precedence.
      if (err_event) begin
        err_flag  <= 1'b1;
        err_addr  <= mem_addr;
        if (err_clr)                 err_count <= 8'd1;
        else if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end else if (err_clr) begin
        err_flag  <= 1'b0;
        err_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_picosoc_bus_xbar.sv
// Bench for picosoc_bus_xbar: three instances (combinational, registered, overlapping map)
// driven one at a time against a small slave model and an expected-response queue.
module tb_picosoc_bus_xbar;
  localparam int NS = 2;
  localparam logic [32*NS-1:0] BASE_STD = {32'h0200_0000, 32'h0000_0000};
  localparam logic [32*NS-1:0] MASK_STD = {32'hFF00_0000, 32'hFFFF_FC00};
  localparam logic [32*NS-1:0] BASE_OVL = {32'h0000_0000, 32'h0000_0000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, mv_a, mv_b, mv_c, instr, err_clr;
  logic [31:0]     addr, wdata;
  logic [3:0]      wstrb;
  logic [NS-1:0]   s_ready;
  logic [32*NS-1:0] s_rdata;

  logic          rdy_a, rdy_b, rdy_c, si_a, si_b, si_c, ef_a, ef_b, ef_c;
  logic [31:0]   rd_a, rd_b, rd_c, sa_a, sa_b, sa_c, swd_a, swd_b, swd_c, ea_a, ea_b, ea_c;
  logic [3:0]    sws_a, sws_b, sws_c;
  logic [NS-1:0] sv_a, sv_b, sv_c;
  logic [7:0]    ec_a, ec_b, ec_c;

  picosoc_bus_xbar #(.NUM_SLAVES(NS), .SLAVE_BASE(BASE_STD), .SLAVE_MASK(MASK_STD),
                     .TIMEOUT_CYCLES(4), .REG_RESPONSE(1'b0), .ERR_DATA(32'hDEAD_BEEF)) dut_a (
    .clk(clk), .reset(reset), .mem_valid(mv_a), .mem_instr(instr), .mem_ready(rdy_a),
    .mem_addr(addr), .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_rdata(rd_a),
    .s_valid(sv_a), .s_ready(s_ready), .s_addr(sa_a), .s_wdata(swd_a), .s_wstrb(sws_a),
    .s_instr(si_a), .s_rdata(s_rdata), .err_flag(ef_a), .err_addr(ea_a), .err_count(ec_a),
    .err_clr(err_clr));

  picosoc_bus_xbar #(.NUM_SLAVES(NS), .SLAVE_BASE(BASE_STD), .SLAVE_MASK(MASK_STD),
                     .TIMEOUT_CYCLES(4), .REG_RESPONSE(1'b1), .ERR_DATA(32'hDEAD_BEEF)) dut_b (
    .clk(clk), .reset(reset), .mem_valid(mv_b), .mem_instr(instr), .mem_ready(rdy_b),
    .mem_addr(addr), .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_rdata(rd_b),
    .s_valid(sv_b), .s_ready(s_ready), .s_addr(sa_b), .s_wdata(swd_b), .s_wstrb(sws_b),
    .s_instr(si_b), .s_rdata(s_rdata), .err_flag(ef_b), .err_addr(ea_b), .err_count(ec_b),
    .err_clr(err_clr));

  picosoc_bus_xbar #(.NUM_SLAVES(NS), .SLAVE_BASE(BASE_OVL), .SLAVE_MASK(MASK_STD),
                     .TIMEOUT_CYCLES(4), .REG_RESPONSE(1'b0), .ERR_DATA(32'hDEAD_BEEF)) dut_c (
    .clk(clk), .reset(reset), .mem_valid(mv_c), .mem_instr(instr), .mem_ready(rdy_c),
    .mem_addr(addr), .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_rdata(rd_c),
    .s_valid(sv_c), .s_ready(s_ready), .s_addr(sa_c), .s_wdata(swd_c), .s_wstrb(sws_c),
    .s_instr(si_c), .s_rdata(s_rdata), .err_flag(ef_c), .err_addr(ea_c), .err_count(ec_c),
    .err_clr(err_clr));

  // Slave model: slave i answers after swait[i] cycles of s_valid; stray forces s_ready.
  logic [NS-1:0] sv_any, sen, stray;
  int            swait [NS];
  int            vcnt  [NS];
  assign sv_any = sv_a | sv_b | sv_c;

  always @(posedge clk)
    for (int i = 0; i < NS; i++) vcnt[i] <= sv_any[i] ? vcnt[i] + 1 : 0;

  always_comb begin
    s_ready = '0;
    for (int i = 0; i < NS; i++)
      s_ready[i] = (sv_any[i] && sen[i] && (vcnt[i] >= swait[i])) || stray[i];
  end

  int            which;
  logic          cur_ready;
  logic [31:0]   cur_rdata;
  logic [NS-1:0] cur_sv;
  always_comb begin
    case (which)
      1:       begin cur_ready = rdy_b; cur_rdata = rd_b; cur_sv = sv_b; end
      2:       begin cur_ready = rdy_c; cur_rdata = rd_c; cur_sv = sv_c; end
      default: begin cur_ready = rdy_a; cur_rdata = rd_a; cur_sv = sv_a; end
    endcase
  end

  typedef struct {
    logic [31:0]   data;
    int            lat;
    int            svc;
    logic [NS-1:0] pat;
  } exp_t;
  exp_t sb [$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One master transaction on the chosen instance; expectation queued at drive time.
  task automatic access(input int dut, input logic [31:0] a, input logic [3:0] ws,
                        input bit clr, input int lat, input logic [31:0] data,
                        input int svc_exp, input logic [NS-1:0] pat_exp);
    exp_t          e;
    int            n, svc;
    logic [NS-1:0] pat;
    bit            done;
    e.data = data; e.lat = lat; e.svc = svc_exp; e.pat = pat_exp;
    sb.push_back(e);
    which = dut; addr = a; wstrb = ws; wdata = a ^ 32'h5A5A_0000; err_clr = clr;
    case (dut)
      1: mv_b = 1'b1;
      2: mv_c = 1'b1;
      default: mv_a = 1'b1;
    endcase
    n = 1; svc = 0; pat = '0; done = 1'b0;
    while (!done && n < 60) begin
      @(negedge clk);
      err_clr = 1'b0;
      n++;
      if (cur_sv != '0) begin svc++; pat = pat | cur_sv; end
      if (cur_ready) done = 1'b1;
    end
    e = sb.pop_front();
    check("ready_within_bound", 32'(done), 32'd1);
    check("latency", 32'(n), 32'(e.lat));
    check("rdata", cur_rdata, e.data);
    check("s_valid_cycles", 32'(svc), 32'(e.svc));
    check("s_valid_pattern", 32'(pat), 32'(e.pat));
    @(posedge clk);
    #1;
    mv_a = 1'b0; mv_b = 1'b0; mv_c = 1'b0;
    @(negedge clk);
    check("ready_not_back_to_back", 32'(cur_ready), 32'd0);
  endtask

  initial begin
    reset = 1'b1; mv_a = 1'b0; mv_b = 1'b0; mv_c = 1'b0; instr = 1'b0; err_clr = 1'b0;
    addr = '0; wdata = '0; wstrb = '0; which = 0;
    sen = 2'b11; stray = 2'b00; swait[0] = 0; swait[1] = 0;
    s_rdata = {32'hCAFE_0001, 32'h1234_5678};
    repeat (2) @(negedge clk);
    check("rst_mem_ready", 32'(rdy_a), 32'd0);
    check("rst_s_valid", 32'(sv_a), 32'd0);
    check("rst_mem_rdata", rd_a, 32'd0);
    check("rst_err_flag", 32'(ef_a), 32'd0);
    check("rst_err_count", 32'(ec_a), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // zero-wait read, combinational response
    access(0, 32'h0000_0010, 4'h0, 1'b0, 2, 32'h1234_5678, 1, 2'b01);
    check("s_addr_broadcast", sa_a, 32'h0000_0010);
    // same read through the registered response path
    access(1, 32'h0000_0010, 4'h0, 1'b0, 3, 32'h1234_5678, 1, 2'b01);
    // unmapped read
    access(0, 32'h0100_0000, 4'h0, 1'b0, 2, 32'hDEAD_BEEF, 0, 2'b00);
    check("unmapped_err_flag", 32'(ef_a), 32'd1);
    check("unmapped_err_addr", ea_a, 32'h0100_0000);
    check("unmapped_err_count", 32'(ec_a), 32'd1);
    // hung slave 1 times out after 4 ACTIVE cycles
    sen[1] = 1'b0;
    access(0, 32'h0200_0010, 4'h0, 1'b0, 6, 32'hDEAD_BEEF, 4, 2'b10);
    check("timeout_err_count", 32'(ec_a), 32'd2);
    check("timeout_err_addr", ea_a, 32'h0200_0010);
    // good access with wait states; stray ready on the unselected slave is ignored
    sen[1] = 1'b1; swait[1] = 2; stray[0] = 1'b1;
    access(0, 32'h0200_0020, 4'h0, 1'b0, 4, 32'hCAFE_0001, 3, 2'b10);
    stray[0] = 1'b0;
    check("good_after_timeout_err_count", 32'(ec_a), 32'd2);
    // write with one wait state
    swait[1] = 1;
    access(0, 32'h0200_0100, 4'hF, 1'b0, 3, 32'hCAFE_0001, 2, 2'b10);
    check("s_wstrb_broadcast", 32'(sws_a), 32'h0000_000F);
    // overlapping regions: lowest index wins
    swait[1] = 0;
    access(2, 32'h0000_0000, 4'h0, 1'b0, 2, 32'h1234_5678, 1, 2'b01);

    // reset while ACTIVE on a hung slave
    sen[1] = 1'b0; which = 0; addr = 32'h0200_0000; wstrb = 4'h0; mv_a = 1'b1;
    repeat (2) @(negedge clk);
    check("pre_reset_s_valid", 32'(sv_a), 32'(2'b10));
    reset = 1'b1; mv_a = 1'b0;
    @(negedge clk);
    check("midrst_s_valid", 32'(sv_a), 32'd0);
    check("midrst_mem_ready", 32'(rdy_a), 32'd0);
    check("midrst_mem_rdata", rd_a, 32'd0);
    check("midrst_err_flag", 32'(ef_a), 32'd0);
    check("midrst_err_addr", ea_a, 32'd0);
    check("midrst_err_count", 32'(ec_a), 32'd0);
    reset = 1'b0; sen[1] = 1'b1;
    @(negedge clk);

    // error counter saturation, then clear coincident with the 300th error
    for (int k = 1; k <= 300; k++) begin
      access(0, 32'h0100_0000, 4'h0, (k == 300), 2, 32'hDEAD_BEEF, 0, 2'b00);
      if (k == 255) check("err_count_at_255", 32'(ec_a), 32'd255);
      if (k == 299) check("err_count_saturated", 32'(ec_a), 32'd255);
    end
    check("clr_coincident_count", 32'(ec_a), 32'd1);
    check("clr_coincident_flag", 32'(ef_a), 32'd1);
    check("clr_coincident_addr", ea_a, 32'h0100_0000);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("clr_alone_count", 32'(ec_a), 32'd0);
    check("clr_alone_flag", 32'(ef_a), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
